redmule_x_feeder: RTL and testbench

//  Upstream stage of the X buffer: takes the DW-wide X operand stream from the streamer (valid/ready),

---
 rtl/redmule_x_feeder.sv | 138 +++++++++++++
 tb/tb_redmule_x_feeder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/redmule_x_feeder.sv
// redmule_x_feeder
//  Upstream stage of the X buffer. X operand words arrive from the streamer on a
//  valid/ready stream and are queued in a small FIFO. Each FIFO word becomes one
//  x-buffer load. Loads are paced per tile: a tile is n_loads words, and after a
//  tile is loaded the feeder waits for the X buffer to drain before it starts the
//  next tile. A done pulse follows the last tile.
// Ports
//  clk_i, rst_ni         clock / async active-low reset
//  clear_i               synchronous clear, same effect as reset
//  start_i               job start pulse, latches n_loads_i / n_tiles_i (0 -> 1)
//  x_data_i/x_valid_i/x_ready_o   input stream
//  xbuf_full_i/xbuf_empty_i       X buffer status
//  x_load_o/x_data_o     x-buffer load strobe and data (FIFO head)
//  busy_o, done_o        job status
module redmule_x_feeder #(
  parameter int unsigned DW         = 288,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_loads_i,
  input  logic [CNT_W-1:0] n_tiles_i,
  input  logic [DW-1:0]    x_data_i,
  input  logic             x_valid_i,
  output logic             x_ready_o,
  input  logic             xbuf_full_i,
  input  logic             xbuf_empty_i,
  output logic             x_load_o,
  output logic [DW-1:0]    x_data_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW    = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FILL, WAIT, DONE} state_e;

  state_e state_q, state_d;

  logic [FIFO_DEPTH-1:0][DW-1:0] mem;
  logic [PTR_W-1:0]              rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]                 cnt_q;

  logic [CNT_W-1:0] n_loads_q, n_tiles_q;
  logic [CNT_W-1:0] load_cnt_q, tile_cnt_q;

  logic push, pop, last_load, last_tile, flush, go;

  // Ready depends only on registered occupancy, so a pop never combinationally
  // reopens the stream; the slot frees up one cycle after the pop.
  assign x_ready_o = ((state_q == FILL) || (state_q == WAIT)) && (cnt_q < CW'(FIFO_DEPTH));
  assign x_load_o  = (state_q == FILL) && (cnt_q != '0) && !xbuf_full_i;
  assign x_data_o  = (cnt_q != '0) ? mem[rd_ptr_q] : '0;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);

  assign push      = x_valid_i && x_ready_o;
  assign pop       = x_load_o;
  assign last_load = x_load_o && (load_cnt_q == n_loads_q - CNT_W'(1));
  assign last_tile = (tile_cnt_q == n_tiles_q - CNT_W'(1));
  assign go        = (state_q == IDLE) && start_i;

  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) state_d = FILL;
      FILL: if (last_load) state_d = WAIT;
      WAIT: if (xbuf_empty_i) state_d = last_tile ? DONE : FILL;
      DONE: begin
        // Words prefetched past the end of the job are dropped here.
        state_d = IDLE;
        flush   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      state_q <= IDLE;
    else if (clear_i) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // FIFO pointers/occupancy; depth is a power of 2 so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to 0 while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= x_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_loads_q  <= '0;
      n_tiles_q  <= '0;
      load_cnt_q <= '0;
      tile_cnt_q <= '0;
    end else if (clear_i) begin
      n_loads_q  <= '0;
      n_tiles_q  <= '0;
      load_cnt_q <= '0;
      tile_cnt_q <= '0;
    end else if (go) begin
      n_loads_q  <= (n_loads_i == '0) ? CNT_W'(1) : n_loads_i;
      n_tiles_q  <= (n_tiles_i == '0) ? CNT_W'(1) : n_tiles_i;
      load_cnt_q <= '0;
      tile_cnt_q <= '0;
    end else begin
      if (x_load_o) load_cnt_q <= last_load ? '0 : load_cnt_q + CNT_W'(1);
      if ((state_q == WAIT) && xbuf_empty_i && !last_tile)
        tile_cnt_q <= tile_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_redmule_x_feeder.sv
module tb_redmule_x_feeder;
  localparam int DW = 288;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_ni, clear_i, start_i, x_valid_i, x_ready_o;
  logic xbuf_full_i, xbuf_empty_i, x_load_o, busy_o, done_o;
  logic [CNT_W-1:0] n_loads_i, n_tiles_i;
  logic [DW-1:0] x_data_i, x_data_o;

  always #5 clk = ~clk;

  redmule_x_feeder #(.DW(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .n_loads_i(n_loads_i), .n_tiles_i(n_tiles_i),
    .x_data_i(x_data_i), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
    .xbuf_full_i(xbuf_full_i), .xbuf_empty_i(xbuf_empty_i),
    .x_load_o(x_load_o), .x_data_o(x_data_o), .busy_o(busy_o), .done_o(done_o)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: job phase, tile progress, and the queue of accepted words
  // that have not yet been loaded (the scoreboard).
  typedef enum {M_IDLE, M_FILL, M_WAIT, M_DONE} phase_e;
  phase_e phase = M_IDLE;
  logic [DW-1:0] sb[$];
  int nl_m = 1, nt_m = 1, loads_m = 0, tiles_m = 0, total_loads = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW+31:0] t;
    t = '0;
    for (int i = 0; i < DW; i += 32) t[i +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  // Monitor: compares the DUT against the model at every falling edge, then
  // advances the model by the events of this cycle.
  always @(negedge clk) begin
    logic exp_ready, exp_load;
    logic [DW-1:0] exp_head;
    if (!rst_ni) begin
      chk("rst_ready", DW'(x_ready_o), '0);
      chk("rst_load", DW'(x_load_o), '0);
      chk("rst_data", x_data_o, '0);
      chk("rst_busy", DW'(busy_o), '0);
      chk("rst_done", DW'(done_o), '0);
      sb.delete();
      phase = M_IDLE;
    end else begin
      exp_ready = ((phase == M_FILL) || (phase == M_WAIT)) && (sb.size() < DEPTH);
      exp_load  = (phase == M_FILL) && (sb.size() > 0) && !xbuf_full_i;
      exp_head  = (sb.size() > 0) ? sb[0] : '0;
      chk("ready", DW'(x_ready_o), DW'(exp_ready));
      chk("load", DW'(x_load_o), DW'(exp_load));
      chk("data", x_data_o, exp_head);
      chk("busy", DW'(busy_o), DW'(phase != M_IDLE));
      chk("done", DW'(done_o), DW'(phase == M_DONE));
      if (clear_i) begin
        sb.delete();
        phase = M_IDLE;
      end else begin
        if (exp_load) begin
          void'(sb.pop_front());
          total_loads++;
        end
        if (x_valid_i && exp_ready) sb.push_back(x_data_i);
        case (phase)
          M_IDLE: if (start_i) begin
            nl_m = (n_loads_i == 0) ? 1 : int'(n_loads_i);
            nt_m = (n_tiles_i == 0) ? 1 : int'(n_tiles_i);
            loads_m = 0; tiles_m = 0; total_loads = 0;
            phase = M_FILL;
          end
          M_FILL: if (exp_load) begin
            loads_m++;
            if (loads_m == nl_m) begin loads_m = 0; phase = M_WAIT; end
          end
          M_WAIT: if (xbuf_empty_i) begin
            tiles_m++;
            phase = (tiles_m == nt_m) ? M_DONE : M_FILL;
          end
          M_DONE: begin
            chk("job_loads", DW'(total_loads), DW'(nl_m * nt_m));
            sb.delete();
            phase = M_IDLE;
          end
          default: phase = M_IDLE;
        endcase
      end
    end
  end

  task automatic idle_inputs();
    start_i = 0; clear_i = 0; x_valid_i = 0; x_data_i = '0;
    xbuf_full_i = 0; xbuf_empty_i = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst_ni = 0;
    idle_inputs();
    repeat (cycles) @(posedge clk);
    #1 rst_ni = 1;
  endtask

  task automatic pulse_start(input int nl, input int nt);
    @(posedge clk); #1;
    n_loads_i = CNT_W'(nl); n_tiles_i = CNT_W'(nt); start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  // Drive random stream / buffer activity until the model returns to IDLE.
  task automatic run_job(input int nl, input int nt, input int full_hold,
                         input int vprob, input int fprob, input int eprob, input bit rnd_start);
    int cyc;
    pulse_start(nl, nt);
    cyc = 0;
    while (phase != M_IDLE && cyc < 3000) begin
      x_valid_i    = ($urandom_range(99) < vprob);
      x_data_i     = rnd_word();
      xbuf_full_i  = (cyc < full_hold) || ($urandom_range(99) < fprob);
      xbuf_empty_i = ($urandom_range(99) < eprob);
      start_i      = rnd_start && ($urandom_range(99) < 5);
      @(posedge clk); #1;
      cyc++;
    end
    idle_inputs();
    if (cyc >= 3000) begin
      tests++; fails++;
      $display("FAIL job_timeout nl=%0d nt=%0d: still busy after %0d cycles", nl, nt, cyc);
      do_reset(2);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    rst_ni = 0;
    n_loads_i = '0; n_tiles_i = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst_ni = 1;
    repeat (2) @(posedge clk);
    #1;

    // Single tile, back-to-back words.
    run_job(4, 1, 0, 100, 0, 30, 0);
    // Backpressure: buffer full long enough for the FIFO to fill.
    run_job(6, 1, 15, 100, 0, 30, 0);
    // Multi-tile with prefetch during WAIT.
    run_job(2, 3, 0, 80, 10, 15, 0);
    // Continuous stream, one load per cycle, pointers wrap.
    run_job(10, 1, 0, 100, 0, 50, 0);
    // Zero config behaves as 1/1; stray starts while busy.
    run_job(0, 0, 0, 70, 20, 30, 1);
    for (int j = 0; j < 15; j++)
      run_job($urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(0, 6),
              $urandom_range(30, 100), $urandom_range(0, 40), $urandom_range(5, 50), 1);

    // Reset mid-FILL with 3 words queued.
    pulse_start(8, 1);
    xbuf_full_i = 1;
    for (int i = 0; i < 3; i++) begin
      x_valid_i = 1; x_data_i = rnd_word();
      @(posedge clk); #1;
    end
    x_valid_i = 0;
    chk("queued3", DW'(sb.size()), DW'(3));
    do_reset(2);
    repeat (2) @(posedge clk);
    #1;

    // Clear mid-WAIT: no done pulse, back to idle.
    pulse_start(2, 2);
    cyc = 0;
    while (phase != M_WAIT && cyc < 200) begin
      x_valid_i = 1; x_data_i = rnd_word();
      @(posedge clk); #1;
      cyc++;
    end
    chk("reach_wait", DW'(phase == M_WAIT), DW'(1));
    @(posedge clk); #1;
    clear_i = 1;
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;

    // Normal job after clear still works.
    run_job(3, 2, 0, 90, 10, 30, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
